// File: rtl/rd_ptr_empty_ctrl.sv
// Read-side pointer, empty/almost-empty flags and fill level for an async FIFO.
// Define RD_UNDERFLOW_STICKY_EN to make underflow hold until a reset instead of pulsing.
module rd_ptr_empty_ctrl #(
    parameter int unsigned ADDRESS_WIDTH = 4,
    parameter int unsigned SOFT_RESET    = 0,
    parameter int unsigned AEMPTY_THRESH = 2
) (
    input  logic                     clk,
    input  logic                     hw_rst_n,
    input  logic                     sw_rst,
    input  logic                     rd_en,
    input  logic [ADDRESS_WIDTH:0]   sync_wptr,
    output logic [ADDRESS_WIDTH:0]   rd_ptr,
    output logic [ADDRESS_WIDTH-1:0] raddr,
    output logic                     rdempty,
    output logic                     rd_almost_empty,
    output logic [ADDRESS_WIDTH:0]   rd_level,
    output logic                     underflow
);

    localparam int unsigned PtrW      = ADDRESS_WIDTH + 1;
    localparam bit          SoftRstEn = (SOFT_RESET == 1) || (SOFT_RESET == 3);

    logic [PtrW-1:0] rbin_q, rbin_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] rd_level_q, rd_level_d;
    logic [PtrW-1:0] wbin;
    logic            rdempty_q, rdempty_d;
    logic            aempty_q, aempty_d;
    logic            underflow_q, underflow_d;
    logic            rd_accept, rd_reject;

    // Binary bit i is the XOR of all Gray bits from i up to the MSB.
    always_comb begin
        wbin = '0;
        for (int i = 0; i < PtrW; i++) begin
            wbin[i] = ^(sync_wptr >> i);
        end
    end

    always_comb begin
        rd_accept  = rd_en & ~rdempty_q;
        rd_reject  = rd_en & rdempty_q;
        rbin_d     = rbin_q + {{ADDRESS_WIDTH{1'b0}}, rd_accept};
        rd_ptr_d   = (rbin_d >> 1) ^ rbin_d;
        rd_level_d = wbin - rbin_d;
        rdempty_d  = (rd_ptr_d == sync_wptr);
        aempty_d   = (32'(rd_level_d) <= AEMPTY_THRESH);
`ifdef RD_UNDERFLOW_STICKY_EN
        underflow_d = underflow_q | rd_reject;
`else
        underflow_d = rd_reject;
`endif
        // Soft reset wins over any read issued in the same cycle.
        if (SoftRstEn && sw_rst) begin
            rbin_d      = '0;
            rd_ptr_d    = '0;
            rd_level_d  = '0;
            rdempty_d   = 1'b1;
            aempty_d    = 1'b1;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge hw_rst_n) begin
        if (!hw_rst_n) begin
            rbin_q      <= '0;
            rd_ptr_q    <= '0;
            rd_level_q  <= '0;
            rdempty_q   <= 1'b1;
            aempty_q    <= 1'b1;
            underflow_q <= 1'b0;
        end else begin
            rbin_q      <= rbin_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_level_q  <= rd_level_d;
            rdempty_q   <= rdempty_d;
            aempty_q    <= aempty_d;
            underflow_q <= underflow_d;
        end
    end

    assign rd_ptr          = rd_ptr_q;
    assign raddr           = rbin_q[ADDRESS_WIDTH-1:0];
    assign rdempty         = rdempty_q;
    assign rd_almost_empty = aempty_q;
    assign rd_level        = rd_level_q;
    assign underflow       = underflow_q;

endmodule
